// File: rtl/pe_array_drain_pkg.sv
// rtl/pe_array_drain_pkg.sv - shared array parameters, width helper, drain tag and FSM state types
package pe_array_drain_pkg;

   localparam int BATCH = 1;
   localparam int RES_W = 16;

   // Bits needed to index n items; never less than one.
   function automatic int bw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int DRAIN_PE_NUM    = 32;
   localparam int DRAIN_GRP_SIZE  = 4;
   localparam int DRAIN_BUF_DEPTH = 256;
   localparam int DRAIN_GRP_W     = bw(DRAIN_PE_NUM / DRAIN_GRP_SIZE);
   localparam int DRAIN_ADDR_W    = bw(DRAIN_BUF_DEPTH);

   typedef struct packed {
      logic [DRAIN_GRP_W-1:0]  grp;
      logic [DRAIN_ADDR_W-1:0] addr;
      logic                    last;
   } drain_tag_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      FLUSH,
      FIN
   } drain_state_t;

endpackage

// File: rtl/pe_array_drain_if.sv
// rtl/pe_array_drain_if.sv - result beat stream from the drain sequencer to the writeback path
interface pe_array_drain_if #(
   parameter int DATA_W = 64,
   parameter int GRP_W  = 3,
   parameter int ADDR_W = 8
);
   logic [DATA_W-1:0] out_data;
   logic [GRP_W-1:0]  out_grp;
   logic [ADDR_W-1:0] out_addr;
   logic              out_last;
   logic              out_valid;
   logic              out_ready;

   modport master (output out_data, out_grp, out_addr, out_last, out_valid, input out_ready);
   modport slave  (input out_data, out_grp, out_addr, out_last, out_valid, output out_ready);
endinterface

// File: rtl/pe_array_drain_fifo.sv
// rtl/pe_array_drain_fifo.sv - first-word fall-through FIFO with registered occupancy count
module drain_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             do_wr, do_rd;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_wr   = wr_valid && (count != CNT_W'(DEPTH));
   assign do_rd   = rd_ready && (count != '0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
         if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
         if (do_wr && !do_rd)
            count <= count + CNT_W'(1);
         else if (!do_wr && do_rd)
            count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/pe_array_drain.sv
// rtl/pe_array_drain.sv - credit-controlled readout sequencer for the PE array accumulation buffers
module pe_array_drain
   import pe_array_drain_pkg::*;
#(
   parameter int PE_NUM     = DRAIN_PE_NUM,
   parameter int GRP_SIZE   = DRAIN_GRP_SIZE,
   parameter int BUF_DEPTH  = DRAIN_BUF_DEPTH,
   parameter int ADDR_W     = bw(BUF_DEPTH),
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4,
   localparam int GRP_NUM   = PE_NUM / GRP_SIZE,
   localparam int GRP_W     = bw(GRP_NUM),
   localparam int DATA_W    = GRP_SIZE * BATCH * RES_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [GRP_NUM-1:0] grp_mask,
   input  logic [ADDR_W:0]    addr_cnt,
   output logic               busy,
   output logic               done,
   output logic [GRP_W-1:0]   rd_sel,
   output logic [ADDR_W-1:0]  abuf_rd_addr,
   input  logic [DATA_W-1:0]  abuf_rd_data,
   pe_array_drain_if.master   res
);
   localparam int CREDIT_W = $clog2(FIFO_DEPTH + 1);
   localparam int TAG_W    = $bits(drain_tag_t);

   drain_state_t         state, state_nxt;
   logic [GRP_NUM-1:0]   mask_q;
   logic [ADDR_W:0]      cnt_q;
   logic [CREDIT_W-1:0]  credit;
   drain_tag_t           pipe_tag [RD_LAT];
   logic [RD_LAT-1:0]    pipe_vld;
   logic                 issue, pop, grp_end, last_rd, more_grp, first_found;
   logic [GRP_W-1:0]     grp_nxt, first_grp;
   logic [TAG_W+DATA_W-1:0] fifo_rd_data;
   logic [CREDIT_W-1:0]  fifo_count;
   drain_tag_t           head_tag;
   logic [DATA_W-1:0]    head_data;
   logic                 head_vld;

   // {found, index} of the lowest set mask bit strictly above 'from'.
   function automatic logic [GRP_W:0] next_set(input logic [GRP_NUM-1:0] mask, input int from);
      next_set = '0;
      for (int i = GRP_NUM - 1; i >= 0; i--)
         if (mask[i] && (i > from)) next_set = {1'b1, GRP_W'(i)};
   endfunction

   assign {more_grp, grp_nxt}       = next_set(mask_q, int'(rd_sel));
   assign {first_found, first_grp}  = next_set(grp_mask, -1);
   assign issue   = (state == ISSUE) && (credit < CREDIT_W'(FIFO_DEPTH));
   assign pop     = head_vld && res.out_ready;
   assign grp_end = ({1'b0, abuf_rd_addr} == cnt_q - (ADDR_W + 1)'(1));
   assign last_rd = grp_end && !more_grp;

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = (!first_found || addr_cnt == '0) ? FIN : ISSUE;
         ISSUE: begin
            busy = 1'b1;
            if (issue && last_rd) state_nxt = FLUSH;
         end
         FLUSH: begin
            busy = 1'b1;
            if (credit == '0) state_nxt = FIN;
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         mask_q       <= '0;
         cnt_q        <= '0;
         rd_sel       <= '0;
         abuf_rd_addr <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            mask_q       <= grp_mask;
            cnt_q        <= addr_cnt;
            rd_sel       <= first_grp;
            abuf_rd_addr <= '0;
         end else if (issue) begin
            if (last_rd) begin
               rd_sel       <= '0;
               abuf_rd_addr <= '0;
            end else if (grp_end) begin
               rd_sel       <= grp_nxt;
               abuf_rd_addr <= '0;
            end else begin
               abuf_rd_addr <= abuf_rd_addr + ADDR_W'(1);
            end
         end
      end
   end

   // Credit covers reads in the array pipe plus FIFO entries, so the FIFO can never overflow.
   always_ff @(posedge clk) begin
      if (!rst) begin
         credit   <= '0;
         pipe_vld <= '0;
      end else begin
         if (issue && !pop)
            credit <= credit + CREDIT_W'(1);
         else if (!issue && pop)
            credit <= credit - CREDIT_W'(1);
         pipe_vld[0] <= issue;
         for (int k = 1; k < RD_LAT; k++) pipe_vld[k] <= pipe_vld[k-1];
      end
   end

   always_ff @(posedge clk) begin
      pipe_tag[0] <= '{grp: rd_sel, addr: abuf_rd_addr, last: last_rd};
      for (int k = 1; k < RD_LAT; k++) pipe_tag[k] <= pipe_tag[k-1];
   end

   drain_fifo #(
      .WIDTH (TAG_W + DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_valid (pipe_vld[RD_LAT-1]),
      .wr_data  ({pipe_tag[RD_LAT-1], abuf_rd_data}),
      .rd_ready (res.out_ready),
      .rd_data  (fifo_rd_data),
      .count    (fifo_count)
   );

   assign {head_tag, head_data} = fifo_rd_data;
   assign head_vld      = (fifo_count != '0);
   assign res.out_valid = head_vld;
   assign res.out_data  = head_vld ? head_data     : '0;
   assign res.out_grp   = head_vld ? head_tag.grp  : '0;
   assign res.out_addr  = head_vld ? head_tag.addr : '0;
   assign res.out_last  = head_vld && head_tag.last;
endmodule
